dot_product_stream_engine: RTL and testbench
============================================

Name: dot_product_stream_engine

Overview:
- Parametrised successor to the fixed 8-element dot-product unit: streams NI-element IEEE-754 single-precision row beats over a valid/ready handshake and returns one 32-bit dot product per job.
- Multiplies with LANES existing `multiply` instances, NI/LANES passes per beat, and accumulates products in a fixed order, so results are bit-exact against a sequential reference model.
- Adds job start/total control, output handshake, error reporting and accumulator chaining across jobs.
- Sits between the row-fetch logic and the CG iteration controller.

Parameters:
- NI, 8, elements (32-bit words) per input beat; even, ≥2.
- LANES, 4, parallel multiplier lanes; NI % LANES == 0.
- MUL_LAT, 6, latency in cycles of the `multiply` unit.
- ADD_LAT, 6, latency in cycles of the fp adder unit.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start; honoured only in IDLE.
- total  in  32  element count of the job; sampled on start.
- acc_continue  in  1  sampled on start. 1 = keep accumulator from previous job; 0 = clear to +0.0.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts a beat this cycle.
- first_row_input  in  32*NI  row A beat; element 0 = bits [32*NI-1 -: 32] (MSB word first).
- second_row_input  in  32*NI  row B beat, same packing as row A.
- dot_product_output  out  32  result, IEEE-754 single.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- finish  out  1  set when the result is accepted; held until the next start or reset.
- busy  out  1  high in every state except IDLE.
- error  out  1  set on a bad job length; cleared by start or reset.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; in_ready = out_valid = finish = busy = error = 0; dot_product_output = 0; accumulator = +0.0.
  - Reset mid-job aborts at once; in-flight products and sums are discarded and no result is emitted.
- States: IDLE, LOAD, MUL, ACC, OUT.
- IDLE, on start:
  - Latch total and beats = total/NI; clear finish and error.
  - If acc_continue = 0, clear the accumulator.
  - If total % NI != 0: set error = 1 and stay in IDLE. No beats are consumed and no result is emitted.
  - If total == 0: go to OUT the next cycle with the current accumulator (+0.0 when cleared).
  - Otherwise go to LOAD.
- LOAD:
  - in_ready = 1.
  - On in_valid && in_ready, register both rows and go to MUL.
  - in_ready drops the cycle after acceptance. Only one beat is in flight.
- MUL:
  - Pass p = 0 .. NI/LANES-1 issues one pass per cycle: lane l receives element p*LANES+l.
  - Products are captured MUL_LAT cycles after issue into the product buffer at index p*LANES+l.
  - Go to ACC once the last product is captured.
- ACC:
  - For k = 0 .. NI-1 in order: acc <= fadd(acc, prod[k]).
  - Each add is issued only after the previous sum is registered, so there are no read-after-write hazards.
  - After k = NI-1: if beats remain, go to LOAD; else go to OUT.
- OUT:
  - out_valid = 1 and dot_product_output = acc.
  - On out_ready: out_valid <= 0, finish <= 1, go to IDLE.
  - out_ready low holds output and state indefinitely.
- start outside IDLE is ignored (no effect on state, total or accumulator).
- Arithmetic:
  - Result equals the sequential model acc = +0.0 (or prior acc); for each beat, for k: acc = fadd(acc, fmul(a_k, b_k)).
  - Rounding follows the `multiply` and adder units' round-to-nearest-even; no special NaN/Inf handling beyond those units.
- Per-beat latency, from acceptance to in_ready re-asserting: at most 1 + NI/LANES + MUL_LAT + NI*(ADD_LAT+1) + 1 cycles.
- in_valid while in_ready = 0: data ignored; the source must hold the beat.

Test Plan:
- NI=8, LANES=4. total=16, two beats, all elements 0x3F800000 (1.0), out_ready=1 → dot_product_output=0x41800000 (16.0); finish=1; out_valid high exactly one cycle.
- total=8. A all 0x40000000 (2.0), B all 0x3F000000 (0.5); out_ready held low 20 cycles then high → output stays 0x41000000 (8.0) with out_valid held; finish rises after the handshake.
- Chaining: job 1 as in the 8.0 test, then start with acc_continue=1, total=8, A=B=1.0 → 0x41800000 (16.0). Repeat with acc_continue=0 → 0x41000000 (8.0).
- total=12 → error=1, in_ready never asserts, no out_valid. total=0 with acc_continue=0 → out_valid with 0x00000000 within 2 cycles.
- Mixed signs: A = {1,-1,2,-2,3,-3,4,-4}.0, B all 1.0 → 0x00000000. in_valid toggling randomly → same result; each beat consumed exactly once.
- reset asserted one cycle mid-ACC of a total=16 job → all outputs 0 next cycle; a following total=8, A=B=1.0 job → 0x41000000 (8.0).

Source files
------------

// File: rtl/dot_product_stream_engine.sv
// Streaming single-precision dot-product engine.
// Each accepted beat of NI element pairs is multiplied on LANES pipelined
// multipliers and then folded into the accumulator one product at a time in
// element order. Results therefore match a plain sequential multiply/add loop
// bit for bit.

// Pipelined IEEE-754 single multiplier, round-to-nearest-even.
// Subnormal inputs are treated as zero and underflow flushes to zero.
module multiply #(
  parameter int LAT = 6
) (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] z);
    logic              s;
    logic              x_nan, z_nan, x_inf, z_inf, x_zero, z_zero;
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [23:0]       m;
    logic              g, st;
    logic [31:0]       r;
    s      = x[31] ^ z[31];
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    z_nan  = (z[30:23] == 8'hFF) && (z[22:0] != 23'd0);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    z_inf  = (z[30:23] == 8'hFF) && (z[22:0] == 23'd0);
    x_zero = (x[30:23] == 8'h00);
    z_zero = (z[30:23] == 8'h00);
    p  = 48'({1'b1, x[22:0]}) * 48'({1'b1, z[22:0]});
    e  = $signed({2'b00, x[30:23]}) + $signed({2'b00, z[30:23]}) - 10'sd127;
    if (p[47]) begin
      e  = e + 10'sd1;
      m  = {1'b0, p[46:24]};
      g  = p[23];
      st = |p[22:0];
    end else begin
      m  = {1'b0, p[45:23]};
      g  = p[22];
      st = |p[21:0];
    end
    if (g && (st || m[0])) m = m + 24'd1;
    if (m[23]) e = e + 10'sd1;
    if (x_nan || z_nan || (x_inf && z_zero) || (z_inf && x_zero)) r = 32'h7FC0_0000;
    else if (x_inf || z_inf)   r = {s, 8'hFF, 23'd0};
    else if (x_zero || z_zero) r = {s, 31'd0};
    else if (e >= 10'sd255)    r = {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)      r = {s, 31'd0};
    else                       r = {s, e[7:0], m[22:0]};
    return r;
  endfunction

  logic [31:0] pipe_q [LAT];

  // Compute on entry, then carry the result through the latency stages.
  always_ff @(posedge clk) begin
    pipe_q[0] <= fmul(a, b);
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign y = pipe_q[LAT-1];

endmodule

// Pipelined IEEE-754 single adder, round-to-nearest-even with guard/round/sticky.
// Subnormal inputs are treated as zero and underflow flushes to zero.
module fp_add #(
  parameter int LAT = 6
) (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  function automatic logic [31:0] fadd(input logic [31:0] p, input logic [31:0] q);
    logic [31:0]       x, z, res;
    logic [7:0]        d;
    logic [26:0]       mx, mz;
    logic [27:0]       r;
    logic signed [9:0] e;
    logic [4:0]        lz;
    logic              found, st, up;
    logic [23:0]       m;
    res = 32'd0;
    if (p[30:23] == 8'hFF)
      res = ((q[30:23] == 8'hFF) && (p[31] != q[31])) ? 32'h7FC0_0000 : p;
    else if (q[30:23] == 8'hFF)
      res = q;
    else if ((p[30:23] == 8'd0) && (q[30:23] == 8'd0))
      res = {p[31] & q[31], 31'd0};
    else if (p[30:23] == 8'd0)
      res = q;
    else if (q[30:23] == 8'd0)
      res = p;
    else begin
      // x carries the larger magnitude so the aligned difference is never negative
      if (p[30:0] >= q[30:0]) begin x = p; z = q; end
      else                    begin x = q; z = p; end
      d  = x[30:23] - z[30:23];
      mx = {1'b1, x[22:0], 3'b000};
      mz = {1'b1, z[22:0], 3'b000};
      if (d >= 8'd27) mz = 27'd1;
      else begin
        st = |(mz & ((27'd1 << d) - 27'd1));
        mz = (mz >> d) | {26'd0, st};
      end
      e = $signed({2'b00, x[30:23]});
      if (x[31] == z[31]) begin
        r = {1'b0, mx} + {1'b0, mz};
        if (r[27]) begin
          r = (r >> 1) | {27'd0, r[0]};
          e = e + 10'sd1;
        end
      end else begin
        r     = {1'b0, mx} - {1'b0, mz};
        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
          if (!found) begin
            if (r[i]) found = 1'b1;
            else      lz = lz + 5'd1;
          end
        end
        r = r << lz;
        e = e - $signed({5'd0, lz});
      end
      if (r == 28'd0) res = 32'd0;
      else begin
        up = r[2] && (r[1] || r[0] || r[3]);
        m  = {1'b0, r[25:3]} + {23'd0, up};
        if (m[23]) e = e + 10'sd1;
        if (e >= 10'sd255)   res = {x[31], 8'hFF, 23'd0};
        else if (e <= 10'sd0) res = {x[31], 31'd0};
        else                 res = {x[31], e[7:0], m[22:0]};
      end
    end
    return res;
  endfunction

  logic [31:0] pipe_q [LAT];

  // Compute on entry, then carry the sum through the latency stages.
  always_ff @(posedge clk) begin
    pipe_q[0] <= fadd(a, b);
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign y = pipe_q[LAT-1];

endmodule

// state | meaning
// IDLE  | waiting for start; error/finish report the last job
// LOAD  | in_ready high, waiting for the next row beat
// MUL   | issuing NI/LANES multiplier passes and capturing products
// ACC   | folding products into acc in element order, one add in flight
// OUT   | out_valid high with the result until out_ready
module dot_product_stream_engine #(
  parameter int NI      = 8,
  parameter int LANES   = 4,
  parameter int MUL_LAT = 6,
  parameter int ADD_LAT = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     total,
  input  logic            acc_continue,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [32*NI-1:0] first_row_input,
  input  logic [32*NI-1:0] second_row_input,
  output logic [31:0]     dot_product_output,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            finish,
  output logic            busy,
  output logic            error
);

  localparam int PASSES = NI / LANES;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int KW     = $clog2(NI);
  localparam logic [PW:0]   NPASS     = (PW+1)'(PASSES);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(NI - 1);
  localparam logic [31:0]   NI32      = 32'(NI);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, OUT} state_t;

  state_t        state;
  logic [31:0]   beats_left;
  logic [31:0]   row_a [NI];
  logic [31:0]   row_b [NI];
  logic [31:0]   prod  [NI];
  logic [31:0]   acc;
  logic [PW:0]   issue_cnt;
  logic          mul_go;
  logic [MUL_LAT-1:0] mul_v;
  logic [PW-1:0] mul_tag [MUL_LAT];
  logic [31:0]   lane_a [LANES];
  logic [31:0]   lane_b [LANES];
  logic [31:0]   lane_y [LANES];
  logic [KW-1:0] k_idx;
  logic          add_issue;
  logic [ADD_LAT-1:0] add_v;
  logic [31:0]   add_y;

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign mul_go   = (state == MUL) && (issue_cnt < NPASS);

  // Steer the current pass's elements onto the multiplier lanes.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_a[l] = 32'd0;
      lane_b[l] = 32'd0;
      if (mul_go) begin
        lane_a[l] = row_a[int'(issue_cnt[PW-1:0]) * LANES + l];
        lane_b[l] = row_b[int'(issue_cnt[PW-1:0]) * LANES + l];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    multiply #(.LAT(MUL_LAT)) u_mul (
      .clk (clk),
      .a   (lane_a[l]),
      .b   (lane_b[l]),
      .y   (lane_y[l])
    );
  end

  fp_add #(.LAT(ADD_LAT)) u_add (
    .clk (clk),
    .a   (acc),
    .b   (prod[k_idx]),
    .y   (add_y)
  );

  // Capture one row beat, element 0 in the most significant word.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      for (int i = 0; i < NI; i++) begin
        row_a[i] <= first_row_input[32*(NI-i)-1 -: 32];
        row_b[i] <= second_row_input[32*(NI-i)-1 -: 32];
      end
    end
  end

  // Track which pass is in each multiplier stage; valids die on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_v <= '0;
      add_v <= '0;
    end else begin
      mul_v[0] <= mul_go;
      for (int i = 1; i < MUL_LAT; i++) mul_v[i] <= mul_v[i-1];
      add_v[0] <= add_issue && (state == ACC);
      for (int i = 1; i < ADD_LAT; i++) add_v[i] <= add_v[i-1];
    end
  end

  // Pass tags and product capture need no reset: they are qualified by mul_v.
  always_ff @(posedge clk) begin
    mul_tag[0] <= issue_cnt[PW-1:0];
    for (int i = 1; i < MUL_LAT; i++) mul_tag[i] <= mul_tag[i-1];
    if (mul_v[MUL_LAT-1]) begin
      for (int l = 0; l < LANES; l++)
        prod[int'(mul_tag[MUL_LAT-1]) * LANES + l] <= lane_y[l];
    end
  end

  // Job control, accumulation order and output handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      out_valid          <= 1'b0;
      finish             <= 1'b0;
      error              <= 1'b0;
      dot_product_output <= 32'd0;
      acc                <= 32'd0;
      beats_left         <= 32'd0;
      issue_cnt          <= '0;
      k_idx              <= '0;
      add_issue          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            finish     <= 1'b0;
            error      <= 1'b0;
            beats_left <= total / NI32;
            if (!acc_continue) acc <= 32'd0;
            if (total % NI32 != 32'd0) begin
              error <= 1'b1;
            end else if (total == 32'd0) begin
              state              <= OUT;
              out_valid          <= 1'b1;
              dot_product_output <= acc_continue ? acc : 32'd0;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            state      <= MUL;
            issue_cnt  <= '0;
            beats_left <= beats_left - 32'd1;
          end
        end
        MUL: begin
          if (mul_go) issue_cnt <= issue_cnt + 1'b1;
          if (mul_v[MUL_LAT-1] && mul_tag[MUL_LAT-1] == PASS_LAST) begin
            state     <= ACC;
            k_idx     <= '0;
            add_issue <= 1'b1;
          end
        end
        ACC: begin
          add_issue <= 1'b0;
          if (add_v[ADD_LAT-1]) begin
            acc <= add_y;
            if (k_idx == K_LAST) begin
              if (beats_left != 32'd0) begin
                state <= LOAD;
              end else begin
                state              <= OUT;
                out_valid          <= 1'b1;
                dot_product_output <= add_y;
              end
            end else begin
              k_idx     <= k_idx + 1'b1;
              add_issue <= 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            finish    <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_stream_engine.sv
// Scenario bench for dot_product_stream_engine: expected results are queued
// when a job is launched and compared when the engine presents its output.
module tb_dot_product_stream_engine;
  localparam int NI = 8;
  localparam int W  = 32 * NI;

  logic          clk;
  logic          reset;
  logic          start;
  logic [31:0]   total;
  logic          acc_continue;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  first_row_input;
  logic [W-1:0]  second_row_input;
  logic [31:0]   dot_product_output;
  logic          out_valid;
  logic          out_ready;
  logic          finish;
  logic          busy;
  logic          error;

  int            checks = 0;
  int            failures = 0;
  int            beat_total = 0;
  logic [31:0]   exp_q [$];

  logic [W-1:0]  ones, halves, twos, mixed;

  dot_product_stream_engine #(.NI(8), .LANES(4), .MUL_LAT(6), .ADD_LAT(6)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .total              (total),
    .acc_continue       (acc_continue),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .first_row_input    (first_row_input),
    .second_row_input   (second_row_input),
    .dot_product_output (dot_product_output),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .finish             (finish),
    .busy               (busy),
    .error              (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (!reset && in_valid && in_ready) beat_total++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [31:0] tot, input bit cont);
    start = 1'b1; total = tot; acc_continue = cont;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      first_row_input  = in_valid ? a : ~a;
      second_row_input = in_valid ? b : ~b;
      if (in_valid && in_ready) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_job(input logic [31:0] tot, input bit cont, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit rnd, output bit ok);
    bit one_ok;
    ok = 1'b1;
    pulse_start(tot, cont);
    for (int i = 0; i < int'(tot / 32'(NI)); i++) begin
      send_beat(a, b, rnd, one_ok);
      if (!one_ok) ok = 1'b0;
    end
  endtask

  task automatic collect(input int hold_low, output bit got, output logic [31:0] data,
                         output int vcycles, output bit stable, output logic fin_early);
    got = 1'b0; data = 32'hxxxx_xxxx; vcycles = 0; stable = 1'b1; fin_early = 1'bx;
    out_ready = (hold_low == 0);
    for (int c = 0; c < 600 && !got; c++) begin
      if (out_valid) got = 1'b1;
      else @(negedge clk);
    end
    if (got) begin
      data = dot_product_output;
      fin_early = finish;
      for (int i = 0; i < hold_low; i++) begin
        vcycles++;
        @(negedge clk);
        if (!out_valid || dot_product_output !== data) stable = 1'b0;
      end
      out_ready = 1'b1;
      vcycles++;
      @(negedge clk);
      while (out_valid && vcycles < 60) begin
        vcycles++;
        @(negedge clk);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({in_ready, out_valid, finish, busy, error} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 00000", {in_ready, out_valid, finish, busy, error});
    end
    checks++;
    if (dot_product_output !== 32'd0) begin
      failures++;
      $display("FAIL reset_output: got %h required 00000000", dot_product_output);
    end
  endtask

  task automatic test_two_beats;
    bit ok, got, stable; logic [31:0] d, e; int vc, b0; logic fe;
    b0 = beat_total;
    exp_q.push_back(32'h4180_0000);
    send_job(32'd16, 1'b0, ones, ones, 1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL two_beats_accept: beats not accepted in time"); end
    collect(0, got, d, vc, stable, fe);
    e = exp_q.pop_front();
    checks++;
    if (!got || d !== e) begin failures++; $display("FAIL two_beats_result: got %h valid=%0d required %h", d, got, e); end
    checks++;
    if (vc != 1) begin failures++; $display("FAIL two_beats_valid_len: got %0d cycles required 1", vc); end
    checks++;
    if (finish !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL two_beats_finish: finish=%b busy=%b required 1 0", finish, busy); end
    checks++;
    if (beat_total - b0 != 2) begin failures++; $display("FAIL two_beats_count: got %0d beats required 2", beat_total - b0); end
  endtask

  task automatic test_backpressure;
    bit ok, got, stable; logic [31:0] d, e; int vc; logic fe;
    exp_q.push_back(32'h4100_0000);
    send_job(32'd8, 1'b0, twos, halves, 1'b0, ok);
    collect(20, got, d, vc, stable, fe);
    e = exp_q.pop_front();
    checks++;
    if (!got || d !== e) begin failures++; $display("FAIL backpressure_result: got %h required %h", d, e); end
    checks++;
    if (!stable || vc != 21) begin failures++; $display("FAIL backpressure_hold: stable=%0d cycles=%0d required 1 21", stable, vc); end
    checks++;
    if (fe !== 1'b0 || finish !== 1'b1) begin failures++; $display("FAIL backpressure_finish: before=%b after=%b required 0 1", fe, finish); end
  endtask

  task automatic test_chaining;
    bit ok, got, stable; logic [31:0] d, e; int vc; logic fe;
    exp_q.push_back(32'h4100_0000);
    send_job(32'd8, 1'b0, twos, halves, 1'b0, ok);
    collect(0, got, d, vc, stable, fe);
    e = exp_q.pop_front();
    checks++;
    if (!got || d !== e) begin failures++; $display("FAIL chain_first: got %h required %h", d, e); end
    exp_q.push_back(32'h4180_0000);
    send_job(32'd8, 1'b1, ones, ones, 1'b0, ok);
    collect(0, got, d, vc, stable, fe);
    e = exp_q.pop_front();
    checks++;
    if (!got || d !== e) begin failures++; $display("FAIL chain_continue: got %h required %h", d, e); end
    exp_q.push_back(32'h4100_0000);
    send_job(32'd8, 1'b0, ones, ones, 1'b0, ok);
    collect(0, got, d, vc, stable, fe);
    e = exp_q.pop_front();
    checks++;
    if (!got || d !== e) begin failures++; $display("FAIL chain_clear: got %h required %h", d, e); end
  endtask

  task automatic test_bad_length;
    bit saw_ready, saw_valid;
    saw_ready = 1'b0; saw_valid = 1'b0;
    pulse_start(32'd12, 1'b0);
    in_valid = 1'b1; first_row_input = ones; second_row_input = ones;
    for (int c = 0; c < 30; c++) begin
      if (in_ready) saw_ready = 1'b1;
      if (out_valid) saw_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bad_length_error: error=%b busy=%b required 1 0", error, busy); end
    checks++;
    if (saw_ready || saw_valid) begin failures++; $display("FAIL bad_length_quiet: in_ready seen=%0d out_valid seen=%0d required 0 0", saw_ready, saw_valid); end
  endtask

  task automatic test_zero_total;
    bit got, stable; logic [31:0] d, e; int vc; logic fe; logic early_valid;
    exp_q.push_back(32'h0000_0000);
    pulse_start(32'd0, 1'b0);
    early_valid = out_valid;
    if (!early_valid) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL zero_total_latency: out_valid=%b within 2 cycles required 1", out_valid); end
    checks++;
    if (error !== 1'b0) begin failures++; $display("FAIL zero_total_error_clear: got %b required 0", error); end
    collect(0, got, d, vc, stable, fe);
    e = exp_q.pop_front();
    checks++;
    if (!got || d !== e) begin failures++; $display("FAIL zero_total_result: got %h required %h", d, e); end
  endtask

  task automatic test_mixed_signs;
    bit ok, got, stable; logic [31:0] d, e; int vc; logic fe;
    exp_q.push_back(32'h0000_0000);
    send_job(32'd8, 1'b0, mixed, ones, 1'b0, ok);
    collect(0, got, d, vc, stable, fe);
    e = exp_q.pop_front();
    checks++;
    if (!got || d !== e) begin failures++; $display("FAIL mixed_signs: got %h required %h", d, e); end
  endtask

  task automatic test_random_valid;
    bit ok, got, stable; logic [31:0] d, e; int vc, b0; logic fe;
    b0 = beat_total;
    exp_q.push_back(32'h0000_0000);
    send_job(32'd24, 1'b0, mixed, ones, 1'b1, ok);
    collect(0, got, d, vc, stable, fe);
    e = exp_q.pop_front();
    checks++;
    if (!ok || !got || d !== e) begin failures++; $display("FAIL random_valid_result: got %h accepted=%0d required %h", d, ok, e); end
    checks++;
    if (beat_total - b0 != 3) begin failures++; $display("FAIL random_valid_count: got %0d beats required 3", beat_total - b0); end
  endtask

  task automatic test_start_ignored;
    bit ok, got, stable; logic [31:0] d, e; int vc; logic fe;
    exp_q.push_back(32'h4180_0000);
    send_job(32'd16, 1'b0, ones, ones, 1'b0, ok);
    pulse_start(32'd12, 1'b0);
    collect(0, got, d, vc, stable, fe);
    e = exp_q.pop_front();
    checks++;
    if (!got || d !== e) begin failures++; $display("FAIL start_ignored_result: got %h required %h", d, e); end
    checks++;
    if (error !== 1'b0) begin failures++; $display("FAIL start_ignored_error: got %b required 0", error); end
  endtask

  task automatic test_reset_mid_acc;
    bit ok, got, stable; logic [31:0] d, e; int vc; logic fe;
    pulse_start(32'd16, 1'b0);
    send_beat(ones, ones, 1'b0, ok);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({in_ready, out_valid, finish, busy, error} !== 5'b0 || dot_product_output !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_acc: flags=%b out=%h required 00000 00000000",
               {in_ready, out_valid, finish, busy, error}, dot_product_output);
    end
    exp_q.push_back(32'h4100_0000);
    send_job(32'd8, 1'b1, ones, ones, 1'b0, ok);
    collect(0, got, d, vc, stable, fe);
    e = exp_q.pop_front();
    checks++;
    if (!got || d !== e) begin failures++; $display("FAIL after_reset_job: got %h required %h", d, e); end
  endtask

  initial begin
    ones   = {NI{32'h3F80_0000}};
    halves = {NI{32'h3F00_0000}};
    twos   = {NI{32'h4000_0000}};
    mixed  = {32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 32'hC000_0000,
              32'h4040_0000, 32'hC040_0000, 32'h4080_0000, 32'hC080_0000};
    reset = 1'b1; start = 1'b0; total = 32'd0; acc_continue = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    first_row_input = '0; second_row_input = '0;
    @(negedge clk);
    test_reset();
    test_two_beats();
    test_backpressure();
    test_chaining();
    test_bad_length();
    test_zero_total();
    test_mixed_signs();
    test_random_valid();
    test_start_ignored();
    test_reset_mid_acc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
